// File: rtl/chacha_block_core.sv
// Iterative ChaCha20 block function: one column or diagonal round per clock,
// then feed-forward addition and a valid/ready hold of the 512-bit block.

module chacha_qr (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  output logic [31:0] na,
  output logic [31:0] nb,
  output logic [31:0] nc,
  output logic [31:0] nd
);
  logic [31:0] a1, b1, c1, d1, a2, b2, c2, d2;
  logic [31:0] dx1, bx1, dx2, bx2;

  always_comb begin
    a1  = a + b;
    dx1 = d ^ a1;
    d1  = {dx1[15:0], dx1[31:16]};
    c1  = c + d1;
    bx1 = b ^ c1;
    b1  = {bx1[19:0], bx1[31:20]};
    a2  = a1 + b1;
    dx2 = d1 ^ a2;
    d2  = {dx2[23:0], dx2[31:24]};
    c2  = c1 + d2;
    bx2 = b1 ^ c2;
    b2  = {bx2[24:0], bx2[31:25]};
    na  = a2;
    nb  = b2;
    nc  = c2;
    nd  = d2;
  end
endmodule

module chacha_block_core #(
  parameter int ROUNDS = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] key,
  input  logic [95:0]  nonce,
  input  logic [31:0]  counter,
  output logic         busy,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] block_out
);
  localparam int RW = (ROUNDS > 2) ? $clog2(ROUNDS) : 1;
  localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);

  // Handshake: block_out is valid while out_valid=1 and transfers on a rising
  // edge with out_valid=1 and out_ready=1; nothing changes until that edge.
  typedef enum logic [1:0] {IDLE, ROUND, ADD, HOLD} state_t;

  state_t            state;
  logic [RW-1:0]     round_cnt;
  logic [15:0][31:0] init_s;
  logic [15:0][31:0] work_s;
  logic [15:0][31:0] load_s;
  logic [15:0][31:0] work_next;
  logic [3:0][31:0]  qa, qb, qc, qd;
  logic [3:0][31:0]  ra, rb, rc, rd;
  logic              diag;

  assign diag = round_cnt[0];

  always_comb begin
    load_s     = '0;
    load_s[0]  = 32'h61707865;
    load_s[1]  = 32'h3320646e;
    load_s[2]  = 32'h79622d32;
    load_s[3]  = 32'h6b206574;
    for (int i = 0; i < 8; i++) load_s[4+i] = key[32*i +: 32];
    load_s[12] = counter;
    for (int j = 0; j < 3; j++) load_s[13+j] = nonce[32*j +: 32];
  end

  // Diagonal rounds rotate rows 1..3 left by 1..3 columns before the QR.
  always_comb begin
    qa = '0;
    qb = '0;
    qc = '0;
    qd = '0;
    for (int k = 0; k < 4; k++) begin
      qa[k] = work_s[k];
      if (diag) begin
        qb[k] = work_s[4 + ((k + 1) % 4)];
        qc[k] = work_s[8 + ((k + 2) % 4)];
        qd[k] = work_s[12 + ((k + 3) % 4)];
      end else begin
        qb[k] = work_s[4 + k];
        qc[k] = work_s[8 + k];
        qd[k] = work_s[12 + k];
      end
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_qr
    chacha_qr u_qr (
      .a  (qa[k]),
      .b  (qb[k]),
      .c  (qc[k]),
      .d  (qd[k]),
      .na (ra[k]),
      .nb (rb[k]),
      .nc (rc[k]),
      .nd (rd[k])
    );
  end

  always_comb begin
    work_next = work_s;
    for (int k = 0; k < 4; k++) begin
      work_next[k] = ra[k];
      if (diag) begin
        work_next[4 + ((k + 1) % 4)]  = rb[k];
        work_next[8 + ((k + 2) % 4)]  = rc[k];
        work_next[12 + ((k + 3) % 4)] = rd[k];
      end else begin
        work_next[4 + k]  = rb[k];
        work_next[8 + k]  = rc[k];
        work_next[12 + k] = rd[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      round_cnt <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      block_out <= '0;
      init_s    <= '0;
      work_s    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            init_s    <= load_s;
            work_s    <= load_s;
            round_cnt <= '0;
            busy      <= 1'b1;
            state     <= ROUND;
          end
        end
        ROUND: begin
          work_s    <= work_next;
          round_cnt <= round_cnt + 1'b1;
          if (round_cnt == LAST_ROUND) state <= ADD;
        end
        ADD: begin
          for (int i = 0; i < 16; i++) block_out[32*i +: 32] <= work_s[i] + init_s[i];
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_chacha_block_core.sv
// Directed bench for chacha_block_core using RFC 8439 keystream vectors.

module tb_chacha_block_core;
  logic         clk;
  logic         rst_n;
  logic         start;
  logic [255:0] key;
  logic [95:0]  nonce;
  logic [31:0]  counter;
  logic         busy;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] block_out;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int episodes = 0;
  logic ov_d = 1'b0;
  logic [31:0] exp_q[$];

  chacha_block_core #(.ROUNDS(20)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .key       (key),
    .nonce     (nonce),
    .counter   (counter),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .block_out (block_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (out_valid && !ov_d) episodes <= episodes + 1;
    ov_d <= out_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word(input logic [511:0] b, input int i);
    return b[32*i +: 32];
  endfunction

  // driver tasks
  task automatic drive_start(input logic [255:0] k, input logic [95:0] n,
                             input logic [31:0] c, output int t0);
    key = k;
    nonce = n;
    counter = c;
    start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    start = 1'b0;
  endtask

  task automatic wait_valid(input bit disturb, output int lat);
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      lat++;
      start = 1'b0;
      if (disturb && (lat == 3 || lat == 10 || lat == 21)) begin
        start = 1'b1;
        key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        nonce = {$urandom, $urandom, $urandom};
        counter = $urandom;
      end
      if (out_valid) break;
    end
    check_eq("valid_seen", out_valid, 1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    start = 1'b0;
    check_eq("hs_valid_low", out_valid, 0);
    check_eq("hs_busy_low", busy, 0);
  endtask

  logic [255:0] std_key;
  logic [95:0]  std_nonce;
  logic [511:0] held;
  logic [511:0] blk_a;
  int t0, t1, lat, ep0;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    key = '0;
    nonce = '0;
    counter = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 32; i++) std_key[8*i +: 8] = 8'(i);
    std_nonce = {32'h00000000, 32'h4a000000, 32'h09000000};

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_block", block_out, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("idle_busy", busy, 0);

    // all-zero vector
    exp_q.push_back(32'hade0b876);
    drive_start('0, '0, 32'd0, t0);
    check_eq("busy_after_start", busy, 1);
    wait_valid(1'b0, lat);
    check_eq("zero_latency", lat, 21);
    check_eq("zero_w0", word(block_out, 0), exp_q.pop_front());
    check_eq("zero_w1", word(block_out, 1), 32'h903df1a0);
    handshake();

    // standard vector with start/input disturbance and backpressure
    @(posedge clk);
    #1;
    ep0 = episodes;
    exp_q.push_back(32'he4e7f110);
    drive_start(std_key, std_nonce, 32'd1, t0);
    wait_valid(1'b1, lat);
    check_eq("std_latency", lat, 21);
    check_eq("std_w0", word(block_out, 0), exp_q.pop_front());
    check_eq("std_w1", word(block_out, 1), 32'h15593bd1);
    check_eq("std_w2", word(block_out, 2), 32'h1fdd0f50);
    check_eq("std_w15", word(block_out, 15), 32'h4e3c50a2);
    held = block_out;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      check_eq("bp_valid", out_valid, 1);
      check_eq("bp_busy", busy, 1);
      check_eq("bp_stable", block_out, held);
    end
    start = 1'b1;
    handshake();
    check_eq("block_kept", block_out, held);
    @(posedge clk);
    #1;
    check_eq("exit_start_ignored", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("one_episode", episodes - ep0, 1);

    // reset in the middle of ROUND
    ep0 = episodes;
    drive_start('0, '0, 32'd0, t0);
    repeat (7) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_valid", out_valid, 0);
    check_eq("abort_block", block_out, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("abort_no_episode", episodes - ep0, 0);
    check_eq("abort_idle", busy, 0);
    exp_q.push_back(32'hade0b876);
    drive_start('0, '0, 32'd0, t0);
    wait_valid(1'b0, lat);
    check_eq("rerun_latency", lat, 21);
    check_eq("rerun_w0", word(block_out, 0), exp_q.pop_front());
    handshake();

    // back-to-back blocks, counter 0 then 1
    @(posedge clk);
    #1;
    exp_q.push_back(32'hade0b876);
    drive_start('0, '0, 32'd0, t0);
    wait_valid(1'b0, lat);
    check_eq("b2b_a_w0", word(block_out, 0), exp_q.pop_front());
    blk_a = block_out;
    handshake();
    @(posedge clk);
    #1;
    exp_q.push_back(32'hbee7079f);
    drive_start('0, '0, 32'd1, t1);
    check_eq("b2b_spacing_ge24", (t1 - t0) >= 24, 1);
    wait_valid(1'b0, lat);
    check_eq("b2b_b_w0", word(block_out, 0), exp_q.pop_front());
    check_eq("b2b_b_w1", word(block_out, 1), 32'h7a385155);
    check_eq("b2b_distinct", block_out != blk_a, 1);
    handshake();

    check_eq("exp_q_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
